// File: rtl/wr_req_arbiter.sv
// -----------------------------------------------------------------------------
// wr_req_arbiter
//   Shares one crossbar slave write port between two masters (M0, M1).
//   Round-robin arbitration; the grant is held until the slave acks or the
//   transaction times out. Address/data/id are latched at grant and the
//   result (ack or err) is returned to the granted master only.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_mX_req/addr/wdata   master X write request (level) and payload
//   o_mX_ack / o_mX_err   1-cycle result pulse to master X
//   o_s_req               request to slave, high for the whole BUSY state
//   o_s_addr/wdata/id     latched payload and granted master, 0 when idle
//   i_s_ack               slave accept, sampled only in BUSY
//   o_busy                high in BUSY or RELEASE
// All outputs are registered.
// -----------------------------------------------------------------------------
module wr_req_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_m0_req,
   input  logic [ADDR_W-1:0] i_m0_addr,
   input  logic [DATA_W-1:0] i_m0_wdata,
   output logic              o_m0_ack,
   output logic              o_m0_err,
   input  logic              i_m1_req,
   input  logic [ADDR_W-1:0] i_m1_addr,
   input  logic [DATA_W-1:0] i_m1_wdata,
   output logic              o_m1_ack,
   output logic              o_m1_err,
   output logic              o_s_req,
   output logic [ADDR_W-1:0] o_s_addr,
   output logic [DATA_W-1:0] o_s_wdata,
   output logic              o_s_id,
   input  logic              i_s_ack,
   output logic              o_busy
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t            state_q,  state_d;
   logic              rr_q,     rr_d;      // master favoured on contention
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              s_req_q,  s_req_d;
   logic [ADDR_W-1:0] s_addr_q, s_addr_d;
   logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
   logic              s_id_q,   s_id_d;
   logic              m0_ack_q, m0_ack_d;
   logic              m0_err_q, m0_err_d;
   logic              m1_ack_q, m1_ack_d;
   logic              m1_err_q, m1_err_d;
   logic              busy_q,   busy_d;
   logic              gnt;

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      s_req_d   = s_req_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_id_d    = s_id_q;
      m0_ack_d  = 1'b0;
      m0_err_d  = 1'b0;
      m1_ack_d  = 1'b0;
      m1_err_d  = 1'b0;
      busy_d    = busy_q;
      gnt       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_m0_req || i_m1_req) begin
               // Sole requester wins; on contention the rr pointer decides.
               gnt       = (i_m0_req && i_m1_req) ? rr_q : i_m1_req;
               s_id_d    = gnt;
               s_addr_d  = gnt ? i_m1_addr  : i_m0_addr;
               s_wdata_d = gnt ? i_m1_wdata : i_m0_wdata;
               s_req_d   = 1'b1;
               cnt_d     = '0;
               busy_d    = 1'b1;
               state_d   = ST_BUSY;
            end
         end

         ST_BUSY: begin
            if (i_s_ack || (cnt_q == CNT_LAST)) begin
               // Ack has priority over a coinciding timeout.
               if (i_s_ack) begin
                  m0_ack_d = ~s_id_q;
                  m1_ack_d =  s_id_q;
               end else begin
                  m0_err_d = ~s_id_q;
                  m1_err_d =  s_id_q;
               end
               rr_d      = ~s_id_q;
               s_req_d   = 1'b0;
               s_addr_d  = '0;
               s_wdata_d = '0;
               s_id_d    = 1'b0;
               state_d   = ST_RELEASE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RELEASE: begin
            // Requests ignored here so the finished master can retire its req.
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         rr_q      <= 1'b0;
         cnt_q     <= '0;
         s_req_q   <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_id_q    <= 1'b0;
         m0_ack_q  <= 1'b0;
         m0_err_q  <= 1'b0;
         m1_ack_q  <= 1'b0;
         m1_err_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
         s_req_q   <= s_req_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_id_q    <= s_id_d;
         m0_ack_q  <= m0_ack_d;
         m0_err_q  <= m0_err_d;
         m1_ack_q  <= m1_ack_d;
         m1_err_q  <= m1_err_d;
         busy_q    <= busy_d;
      end
   end

   assign o_s_req   = s_req_q;
   assign o_s_addr  = s_addr_q;
   assign o_s_wdata = s_wdata_q;
   assign o_s_id    = s_id_q;
   assign o_m0_ack  = m0_ack_q;
   assign o_m0_err  = m0_err_q;
   assign o_m1_ack  = m1_ack_q;
   assign o_m1_err  = m1_err_q;
   assign o_busy    = busy_q;

endmodule

// File: tb/tb_wr_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wr_req_arbiter
//   Directed and randomized transactions against a transaction-level model:
//   the model only knows the round-robin pointer and the rules "grant lasts
//   dly+1 cycles with ack, or TIMEOUT cycles with err".
// -----------------------------------------------------------------------------
module tb_wr_req_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m1_req, s_ack;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
   logic          o_s_req, o_s_id, o_busy;
   logic [AW-1:0] o_s_addr;
   logic [DW-1:0] o_s_wdata;

   int   total = 0;
   int   bad   = 0;
   logic model_ptr = 1'b0;
   int   ack_cnt [2];

   always #5 clk = ~clk;

   wr_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
      .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
      .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
      .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
      .o_s_req(o_s_req), .o_s_addr(o_s_addr), .o_s_wdata(o_s_wdata),
      .o_s_id(o_s_id), .i_s_ack(s_ack), .o_busy(o_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: request, BUSY for the predicted length, result
   // pulse, RELEASE (loser keeps requesting), back to IDLE.
   task automatic run_txn(input logic r0, input logic r1, input int dly,
                          input logic [31:0] a0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [31:0] d1,
                          input bit perturb);
      logic        g;
      logic [31:0] ea, ed;
      bit          exp_ack, held_ok;
      int          len;
      g       = (r0 && r1) ? model_ptr : r1;
      ea      = g ? a1 : a0;
      ed      = g ? d1 : d0;
      exp_ack = (dly <= TO - 1);
      len     = exp_ack ? dly + 1 : TO;

      m0_req = r0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_addr = a1; m1_wdata = d1;
      tick();
      chk("grant_req",  o_s_req,   1);
      chk("grant_id",   o_s_id,    g);
      chk("grant_addr", o_s_addr,  ea);
      chk("grant_data", o_s_wdata, ed);
      chk("grant_busy", o_busy,    1);

      held_ok = 1;
      for (int c = 0; c < len; c++) begin
         if (o_s_req !== 1'b1 || o_s_id !== g || o_s_addr !== ea || o_s_wdata !== ed ||
             {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err} !== 4'b0)
            held_ok = 0;
         s_ack = (c == dly);
         if (perturb) begin
            m0_addr = $urandom; m0_wdata = $urandom; m0_req = 1'($urandom_range(0, 1));
            m1_addr = $urandom; m1_wdata = $urandom; m1_req = 1'($urandom_range(0, 1));
         end
         tick();
      end
      s_ack = 1'b0;
      chk("busy_hold",   held_ok,   1);
      chk("end_req",     o_s_req,   0);
      chk("end_addr",    o_s_addr,  0);
      chk("end_data",    o_s_wdata, 0);
      chk("end_id",      o_s_id,    0);
      chk("ack_win",     g ? o_m1_ack : o_m0_ack, exp_ack);
      chk("err_win",     g ? o_m1_err : o_m0_err, !exp_ack);
      chk("other_quiet", g ? {o_m0_ack, o_m0_err} : {o_m1_ack, o_m1_err}, 0);
      chk("rel_busy",    o_busy,    1);
      if (exp_ack) ack_cnt[g]++;
      model_ptr = ~g;

      if (g) begin m1_req = 1'b0; m0_req = r0; end
      else   begin m0_req = 1'b0; m1_req = r1; end
      tick();
      chk("idle_req",   o_s_req, 0);
      chk("idle_busy",  o_busy,  0);
      chk("pulse_gone", {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}, 0);
      m0_req = 1'b0; m1_req = 1'b0;
   endtask

   initial begin
      int a0_before, a1_before;
      logic [1:0] r;
      rst = 1'b1; s_ack = 1'b0;
      m0_req = 1'b1; m1_req = 1'b1;
      m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
      ack_cnt[0] = 0; ack_cnt[1] = 0;

      // Reset with both masters requesting
      tick(); tick();
      chk("rst_sreq", o_s_req, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_addr", o_s_addr, 0);
      chk("rst_id",   o_s_id, 0);
      chk("rst_resp", {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}, 0);
      rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      model_ptr = 1'b0;
      tick();

      // First contended grant after reset goes to M0
      run_txn(1, 1, 1, 32'h100, 32'h1, 32'h200, 32'h2, 0);

      // Single master M1, ack two BUSY cycles after the first
      run_txn(0, 1, 2, 32'h0, 32'h0, 32'h10, 32'hAB, 0);

      // Contention: four transactions alternate, two acks each
      a0_before = ack_cnt[0]; a1_before = ack_cnt[1];
      for (int i = 0; i < 4; i++)
         run_txn(1, 1, 1, 32'h1000 + i, 32'hA0 + i, 32'h2000 + i, 32'hB0 + i, 0);
      chk("cont_m0_acks", ack_cnt[0] - a0_before, 2);
      chk("cont_m1_acks", ack_cnt[1] - a1_before, 2);

      // Timeout: no ack ever, err after exactly TO cycles
      run_txn(1, 0, TO + 5, 32'hDEAD, 32'hBEEF, 32'h0, 32'h0, 0);
      // Ack on the final timeout cycle wins
      run_txn(1, 0, TO - 1, 32'hCAFE, 32'hF00D, 32'h0, 32'h0, 0);
      // Payload and req changes during BUSY are ignored
      run_txn(1, 0, 5, 32'h55, 32'h66, 32'h0, 32'h0, 1);

      // Pointer now favours M1; reset mid-BUSY must bring it back to M0
      m1_req = 1'b1; m1_addr = 32'h77; m1_wdata = 32'h88;
      tick();
      chk("mid_grant", o_s_req, 1);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_sreq", o_s_req, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_addr", o_s_addr, 0);
      chk("mid_rst_resp", {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}, 0);
      rst = 1'b0; m1_req = 1'b0; s_ack = 1'b1;
      model_ptr = 1'b0;
      tick();
      s_ack = 1'b0;
      chk("post_rst_resp", {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}, 0);
      chk("post_rst_sreq", o_s_req, 0);
      run_txn(1, 1, 0, 32'h300, 32'h3, 32'h400, 32'h4, 0);

      // Randomized traffic
      for (int i = 0; i < 24; i++) begin
         r = 2'($urandom_range(1, 3));
         run_txn(r[0], r[1], $urandom_range(0, TO + 2),
                 $urandom, $urandom, $urandom, $urandom, bit'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
